// File: rtl/boot_mem_pkg.sv
// Shared types and sizing helpers for the boot memory controller.
// The optional run-time write port is enabled by defining BMEM_WRITE_EN.
package boot_mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int             DEFAULT_DATA_W    = 32;
    localparam logic [31:0]    DEFAULT_INIT_WORD = 32'h0000_0013;

    function automatic int calc_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    localparam int BYTE_OFF_W = calc_byte_off_w(DEFAULT_DATA_W);

endpackage

// File: rtl/boot_mem_array.sv
// Boot memory storage: one write port and one registered synchronous read port.
// Read-during-write to the same index returns the previous contents.
module boot_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage has no reset so it maps onto RAM; the init sweep fills it instead.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read data only moves on a read so it doubles as the held response payload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/boot_mem_ctrl.sv
// Boot memory controller: init sweep, valid/ready read port, address checking.
// Define BMEM_WRITE_EN to add the run-time write port.
module boot_mem_ctrl
    import boot_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(DEFAULT_INIT_WORD)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [ADDR_W-1:0] io_req_addr,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data,
    output logic              io_resp_err,
`ifdef BMEM_WRITE_EN
    input  logic              io_wr_en,
    input  logic [ADDR_W-1:0] io_wr_addr,
    input  logic [DATA_W-1:0] io_wr_data,
`endif
    output logic              io_init_done
);

    localparam int               IDX_W    = calc_idx_w(DEPTH);
    localparam int               BOFF_W   = calc_byte_off_w(DATA_W);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BOFF_W) - 1);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        return ((addr & OFF_MASK) != '0) || ((addr >> (BOFF_W + IDX_W)) != '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> BOFF_W);
    endfunction

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  init_cnt;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              req_accept;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == IDX_W'(DEPTH - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    assign io_init_done = (state == ST_RUN);
    assign io_req_ready = (state == ST_RUN) && (!resp_valid_q || io_resp_ready);
    assign req_accept   = io_req_valid && io_req_ready;

    // A new accept overwrites the register even while the old response hands off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else if (req_accept) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= addr_bad(io_req_addr);
        end else if (io_resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_err   = resp_err_q;
    assign io_resp_data  = resp_err_q ? '0 : rd_data;

`ifdef BMEM_WRITE_EN
    logic wr_ok;
    assign wr_ok     = (state == ST_RUN) && io_wr_en && !addr_bad(io_wr_addr);
    assign mem_we    = (state == ST_INIT) || wr_ok;
    assign mem_widx  = (state == ST_INIT) ? init_cnt : addr_idx(io_wr_addr);
    assign mem_wdata = (state == ST_INIT) ? INIT_WORD : io_wr_data;
`else
    assign mem_we    = (state == ST_INIT);
    assign mem_widx  = init_cnt;
    assign mem_wdata = INIT_WORD;
`endif

    boot_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_idx  (mem_widx),
        .wr_data (mem_wdata),
        .rd_en   (req_accept),
        .rd_idx  (addr_idx(io_req_addr)),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Self-checking bench for boot_mem_ctrl: vector table, scoreboard and corner sequences.
// Write-port checks are compiled in when BMEM_WRITE_EN is defined.
module tb_boot_mem_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [31:0] io_req_addr;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_resp_data;
    logic        io_resp_err;
    logic        io_init_done;
    logic        io_wr_en;
    logic [31:0] io_wr_addr;
    logic [31:0] io_wr_data;

    int    n_cmp  = 0;
    int    n_fail = 0;
    resp_t sb[$];
    logic [31:0] model_mem [64];

    always #5 clock = ~clock;

    boot_mem_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_addr   (io_req_addr),
        .io_resp_valid (io_resp_valid),
        .io_resp_ready (io_resp_ready),
        .io_resp_data  (io_resp_data),
        .io_resp_err   (io_resp_err),
`ifdef BMEM_WRITE_EN
        .io_wr_en      (io_wr_en),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data),
`endif
        .io_init_done  (io_init_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic resp_t model_resp(input logic [31:0] addr);
        resp_t r;
        logic  bad;
        bad    = (addr[1:0] != 2'b00) || (addr >= 32'h100);
        r.err  = bad;
        r.data = bad ? 32'h0 : model_mem[addr[7:2]];
        return r;
    endfunction

    // Scoreboard: pop on response handshake, push on request accept, then apply writes.
    always @(negedge clock) begin
        resp_t e;
        if (!reset) begin
            sb.delete();
        end else begin
            if (io_resp_valid && io_resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_err", io_resp_err, e.err);
                    check("sb_data", io_resp_data, e.data);
                end
            end
            if (io_req_valid && io_req_ready) sb.push_back(model_resp(io_req_addr));
            if (io_wr_en && io_wr_addr[1:0] == 2'b00 && io_wr_addr < 32'h100)
                model_mem[io_wr_addr[7:2]] = io_wr_data;
        end
    end

    task automatic wait_init(output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (n < 200) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (io_init_done) break;
            if (io_req_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic issue_read(input string name, input logic [31:0] addr,
                              input logic exp_err, input logic [31:0] exp_data);
        int k;
        @(posedge clock); #1;
        io_req_valid  = 1'b1;
        io_req_addr   = addr;
        io_resp_ready = 1'b1;
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        k = 0;
        @(negedge clock);
        while (!io_resp_valid && k < 8) begin
            @(negedge clock);
            k++;
        end
        check({name, "_valid"}, io_resp_valid, 1);
        check({name, "_err"}, io_resp_err, exp_err);
        check({name, "_data"}, io_resp_data, exp_data);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clock); #1;
        io_wr_en   = 1'b1;
        io_wr_addr = addr;
        io_wr_data = data;
        @(posedge clock); #1;
        io_wr_en = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int   n;
        logic ready_seen;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0013};
        vecs[1] = '{32'h0000_00FC, 1'b0, 32'h0000_0013};
        vecs[2] = '{32'h0000_0010, 1'b0, 32'h0000_0013};
        vecs[3] = '{32'h0000_0002, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h0000_0100, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h0000_0003, 1'b1, 32'h0000_0000};
        vecs[6] = '{32'h8000_0000, 1'b1, 32'h0000_0000};
        vecs[7] = '{32'h0000_0044, 1'b0, 32'h0000_0013};
        vecs[8] = '{32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'h0000_00FF, 1'b1, 32'h0000_0000};

        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0000_0013;

        reset         = 1'b0;
        io_req_valid  = 1'b0;
        io_req_addr   = '0;
        io_resp_ready = 1'b1;
        io_wr_en      = 1'b0;
        io_wr_addr    = '0;
        io_wr_data    = '0;

        @(negedge clock);
        check("rst_req_ready", io_req_ready, 0);
        check("rst_resp_valid", io_resp_valid, 0);
        check("rst_resp_data", io_resp_data, 0);
        check("rst_resp_err", io_resp_err, 0);
        check("rst_init_done", io_init_done, 0);

        // Request held through init must be taken only once init completes.
        @(posedge clock); #1;
        reset        = 1'b1;
        io_req_valid = 1'b1;
        io_req_addr  = 32'h0000_0040;
        wait_init(n, ready_seen);
        check("init_cycles", n, 64);
        check("ready_low_in_init", ready_seen, 0);
        check("held_req_ready", io_req_ready, 1);
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        @(negedge clock);
        check("held_req_resp_valid", io_resp_valid, 1);

        // Back-to-back requests with no backpressure.
        @(posedge clock); #1;
        io_req_valid = 1'b1;
        io_req_addr  = 32'h0000_0000;
        @(posedge clock); #1;
        io_req_addr  = 32'h0000_00FC;
        @(negedge clock);
        check("b2b_first_valid", io_resp_valid, 1);
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        @(negedge clock);
        check("b2b_second_valid", io_resp_valid, 1);
        check("b2b_second_data", io_resp_data, 32'h0000_0013);
        @(negedge clock);
        check("b2b_drain_valid", io_resp_valid, 0);

        for (int i = 0; i < 10; i++)
            issue_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_err, vecs[i].exp_data);

        // Backpressure: response must hold and block new requests.
        @(posedge clock); #1;
        io_resp_ready = 1'b0;
        io_req_valid  = 1'b1;
        io_req_addr   = 32'h0000_0010;
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_valid", io_resp_valid, 1);
            check("hold_data", io_resp_data, 32'h0000_0013);
            check("hold_err", io_resp_err, 0);
            check("hold_req_ready", io_req_ready, 0);
        end
        @(posedge clock); #1;
        io_resp_ready = 1'b1;
        @(negedge clock);
        check("release_req_ready", io_req_ready, 1);
        @(negedge clock);
        check("release_valid_drop", io_resp_valid, 0);
        check("release_ready_after", io_req_ready, 1);

`ifdef BMEM_WRITE_EN
        do_write(32'h0000_0020, 32'hDEAD_BEEF);
        issue_read("wr_read", 32'h0000_0020, 1'b0, 32'hDEAD_BEEF);
        do_write(32'h0000_0022, 32'h1111_1111);
        issue_read("wr_misaligned_dropped", 32'h0000_0020, 1'b0, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        io_wr_en      = 1'b1;
        io_wr_addr    = 32'h0000_0024;
        io_wr_data    = 32'hCAFE_F00D;
        io_req_valid  = 1'b1;
        io_req_addr   = 32'h0000_0024;
        io_resp_ready = 1'b1;
        @(posedge clock); #1;
        io_wr_en     = 1'b0;
        io_req_valid = 1'b0;
        @(negedge clock);
        check("rdw_old_data", io_resp_data, 32'h0000_0013);
        issue_read("rdw_new_data", 32'h0000_0024, 1'b0, 32'hCAFE_F00D);
`endif

        // Reset with a pending response, then reset again mid-init.
        @(posedge clock); #1;
        io_resp_ready = 1'b0;
        io_req_valid  = 1'b1;
        io_req_addr   = 32'h0000_0008;
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        @(negedge clock);
        check("pend_valid", io_resp_valid, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_valid", io_resp_valid, 0);
        check("midrst_ready", io_req_ready, 0);
        check("midrst_done", io_init_done, 0);
        @(posedge clock); #1;
        reset         = 1'b1;
        io_resp_ready = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("init_rst_done", io_init_done, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0000_0013;
        wait_init(n, ready_seen);
        check("reinit_cycles", n, 64);
        check("reinit_ready_low", ready_seen, 0);
        issue_read("post_reinit", 32'h0000_0020, 1'b0, 32'h0000_0013);

        @(negedge clock);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_mem_ctrl.md
Name: boot_mem_ctrl

Overview:
- Parametrised boot memory with a valid/ready request/response interface and one-cycle registered read.
- After reset, a built-in initialisation sweep fills every entry with a default word.
- Serves the core's fetch path during boot. Successor to the fixed-value combinational boot memory: adds configurable width and depth, address checking, backpressure and sequential init.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 64, number of words; power of two, at least 2.
- ADDR_W, 32, byte-address width of io_req_addr.
- INIT_WORD, 32'h00000013, value written to every entry by the init sweep (RISC-V NOP).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- io_req_valid  in  1  read request valid.
- io_req_ready  out  1  controller can accept a request.
- io_req_addr  in  ADDR_W  byte address.
- io_resp_valid  out  1  response valid.
- io_resp_ready  in  1  consumer accepts response.
- io_resp_data  out  DATA_W  read data; 0 when io_resp_err=1.
- io_resp_err  out  1  misaligned or out-of-range request.
- io_init_done  out  1  init sweep complete.

Behaviour:
- Reset values (reset=0): state=INIT, init counter=0, io_req_ready=0, io_resp_valid=0, io_resp_data=0, io_resp_err=0, io_init_done=0. Memory contents are not reset.
- FSM states: INIT and RUN.
  - INIT: one write per cycle, mem[cnt]=INIT_WORD, cnt++. When cnt==DEPTH-1 is written, next state is RUN.
  - Init takes exactly DEPTH cycles after reset deassertion.
  - io_init_done rises on the first RUN cycle and stays 1 until reset.
- RUN state:
  - io_req_ready = !io_resp_valid || io_resp_ready. This is a single-entry output register and allows one request per cycle under no backpressure.
- Accept:
  - A request is accepted when io_req_valid && io_req_ready.
  - Word index = io_req_addr[log2(DATA_W/8)+IDX_W-1 : log2(DATA_W/8)].
- Error: io_req_addr low log2(DATA_W/8) bits nonzero (misaligned), or io_req_addr upper bits above the index field nonzero (out of range). Then io_resp_err=1 and io_resp_data=0.
- Latency: response registered; io_resp_valid=1 on the cycle after acceptance.
- Hold: io_resp_valid, io_resp_data and io_resp_err stay stable until io_resp_valid && io_resp_ready.
- Simultaneous accept and resp handshake: the new response replaces the old one and io_resp_valid stays 1.
- Handshake without a new accept: io_resp_valid clears next cycle.
- Reset mid-operation: any pending response is dropped and init restarts from index 0.
- Requests presented during INIT are not accepted (ready=0) and must stay held by the requester.

Optional Feature:
- Macro: BMEM_WRITE_EN.
- Defined: adds ports io_wr_en (in, 1), io_wr_addr (in, ADDR_W) and io_wr_data (in, DATA_W).
  - Write honoured only in RUN, and only for aligned, in-range addresses. Other writes are silently dropped.
  - Write completes at the clock edge.
  - A read accepted in the same cycle to the same index returns the old data.
- Undefined: write ports absent; memory is written only by the init sweep.

Decomposition:
- Package boot_mem_pkg:
  - state enum {ST_INIT, ST_RUN}.
  - Function computing IDX_W = clog2(DEPTH).
  - Constant BYTE_OFF_W = clog2(DATA_W/8).
  - Default INIT_WORD constant.
- Sub-module: boot_mem_array, the storage array with one write port (init/optional write, muxed by state) and one synchronous read port.
- FSM, address decode and response register stay in the top module.

Test Plan:
- Deassert reset (DEPTH=64) -> io_init_done rises exactly 64 cycles later; io_req_ready=0 throughout INIT.
- After init, request addr 0x0, then 0xFC, resp_ready=1 -> responses on consecutive cycles, data 0x00000013, err=0.
- Request addr 0x10 with resp_ready=0 for 5 cycles -> resp held stable, io_req_ready=0; resp_ready=1 -> valid drops next cycle, ready=1.
- Request addr 0x2 -> err=1, data 0. Request addr 0x100 -> err=1, data 0.
- Assert reset during init at cycle 30, release -> init restarts, io_init_done after a full 64 cycles; pending response cleared.
- With BMEM_WRITE_EN: write 0xDEADBEEF to 0x20 -> later read of 0x20 returns 0xDEADBEEF. Same-cycle read and write to 0x24 -> read returns the old 0x00000013.
